// File: rtl/multibyte_add_seq.sv
// Byte-serial add/subtract sequencer: one byte per cycle through an external
// 8-bit full adder, LSB first, with the carry chained through carry_reg.

// One result byte: loads when its index is being processed, holds otherwise.
module mb_byte_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_s,
  input  logic                  add_cout
);
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [NBYTES-1:0][7:0] a;
    logic [NBYTES-1:0][7:0] b;
  } opnd_t;

  state_t  state, state_nx;
  opnd_t   opnd;
  logic    carry_reg;
  logic [IW-1:0] idx;
  logic    last;
  logic [NBYTES-1:0][7:0] res_q;

  assign last = (idx == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        add_a   = opnd.a[idx];
        add_b   = opnd.b[idx];
        add_cin = carry_reg;
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B at capture and seed the carry with sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd      <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opnd.a    <= op_a;
          opnd.b    <= sub ? ~op_b : op_b;
          carry_reg <= sub;
          idx       <= '0;
        end
        RUN: begin
          carry_reg <= add_cout;
          if (last) carry_out <= add_cout;
          else      idx       <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NBYTES; i++) begin : g_byte
    mb_byte_reg u_byte (
      .clk (clk),
      .rst (rst),
      .we  ((state == RUN) && (idx == IW'(i))),
      .d   (add_s),
      .q   (res_q[i])
    );
  end

  assign result = res_q;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq (NBYTES=4) with an 8-bit full adder model.
module tb_multibyte_add_seq;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] op_a, op_b, result;
  logic         busy, done, carry_out;
  logic [7:0]   add_a, add_b, add_s;
  logic         add_cin, add_cout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation; checks first-byte adder drive, latency, result and idle return.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] er, input logic ec,
                        input logic [7:0] ea0, input logic [7:0] eb0);
    int cnt;
    @(negedge clk);
    start = 1'b1; sub = s; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_add_a0"}, add_a, ea0);
    chk({tag, "_add_b0"}, add_b, eb0);
    chk({tag, "_cin0"}, add_cin, s);
    cnt = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, cnt, NBYTES);
    chk({tag, "_result"}, result, er);
    chk({tag, "_carry"}, carry_out, ec);
    @(negedge clk);
    chk({tag, "_done_clr"}, done, 1'b0);
    chk({tag, "_busy_clr"}, busy, 1'b0);
  endtask

  initial begin
    int ndone;
    int cyc;
    int dc [3];
    int np;

    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_carry", carry_out, 1'b0);
    chk("rst_add_a", add_a, 8'h00);
    chk("rst_add_cin", add_cin, 1'b0);
    rst = 1'b0;

    run_op("add_ff_1",  32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 8'hFF, 8'h01);
    run_op("add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 8'hFF, 8'h01);
    run_op("sub_5_7",   32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 8'h05, 8'hF8);
    run_op("sub_7_5",   32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 8'h07, 8'hFA);

    // Starts during RUN and DONE must be ignored.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 32'h12345678; op_b = 32'h11111111;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (k == 4) chk("ign_done_at_4", done, 1'b1);
      if (k == 1 || k == 4) begin
        start = 1'b1; sub = 1'b1; op_a = 32'hAAAAAAAA; op_b = 32'h55555555;
      end else begin
        start = 1'b0;
      end
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_result", result, 32'h23456789);
    chk("ign_carry", carry_out, 1'b0);
    chk("ign_busy", busy, 1'b0);

    // Reset while byte 2 is being processed.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 32'h01010101; op_b = 32'h01010101;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("prog_result", result, 32'h23450202);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, 32'h0);
    chk("abort_carry", carry_out, 1'b0);
    chk("abort_done", done, 1'b0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op("post_rst", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 8'h01, 8'h01);

    // Continuous start: done every NBYTES+2 cycles.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 32'h0F0F0F0F; op_b = 32'h01010101;
    np = 0;
    cyc = 0;
    while (np < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        dc[np] = cyc;
        chk($sformatf("cont_result_%0d", np), result, 32'h10101010);
        np++;
      end
    end
    start = 1'b0;
    chk("cont_pulses", np, 3);
    if (np == 3) begin
      chk("cont_gap0", dc[1] - dc[0], NBYTES + 2);
      chk("cont_gap1", dc[2] - dc[1], NBYTES + 2);
    end
    repeat (8) @(negedge clk);
    chk("cont_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
